nexys_starship_monster_gen: RTL and testbench

- Upstream spawner for one ship side (top). Drives `top_monster_ctrl` into the top-monster state machine.
- Decides pseudo-randomly when a monster appears, using a free-running LFSR with a guaranteed gap between spawns.
- Runs the monster's shoot-down countdown and raises `top_broken` when the player fails to shoot in time.
- One instance per side; the other sides reuse it with different seeds.

---
 rtl/nexys_starship_pkg.sv | 34 +++
 rtl/nexys_starship_lfsr16.sv | 33 +++
 rtl/nexys_starship_monster_gen.sv | 213 +++++++++++++++++++++
 tb/tb_nexys_starship_monster_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nexys_starship_pkg.sv
// -----------------------------------------------------------------------------
// nexys_starship_pkg
// Shared constants for the starship monster generators.
//   - One-hot encodings for the monster-generator state register.
//   - Galois LFSR tap mask and the matching next-state helper.
//   - Default LFSR seeds, one per ship side, so the sides spawn independently.
// -----------------------------------------------------------------------------
package nexys_starship_pkg;

    typedef logic [4:0] mg_state_t;

    // One-hot state encodings (bit order matches the q_MG_* outputs)
    localparam mg_state_t MG_IDLE   = 5'b00001;
    localparam mg_state_t MG_COOL   = 5'b00010;
    localparam mg_state_t MG_ARMED  = 5'b00100;
    localparam mg_state_t MG_ACTIVE = 5'b01000;
    localparam mg_state_t MG_BROKEN = 5'b10000;

    // Right-shifting Galois LFSR, taps 16,14,13,11 -> mask bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Per-side seeds; all non-zero so no instance can lock up at 0
    localparam logic [15:0] SEED_TOP    = 16'hACE1;
    localparam logic [15:0] SEED_BOTTOM = 16'h1D2B;
    localparam logic [15:0] SEED_LEFT   = 16'h7E55;
    localparam logic [15:0] SEED_RIGHT  = 16'h3C9F;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        logic [15:0] shifted;
        shifted = cur >> 1;
        return cur[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// -----------------------------------------------------------------------------
// nexys_starship_lfsr16
// Free-running 16-bit Galois LFSR, advances on every non-reset clock.
// Ports:
//   Clk    in   system clock
//   Reset  in   synchronous active-high reset, loads SEED
//   state  out  current 16-bit LFSR state (registered)
// Parameters:
//   SEED   reset value; must be non-zero
// -----------------------------------------------------------------------------
module nexys_starship_lfsr16
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] SEED = SEED_TOP
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] state
);

    logic [15:0] state_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= SEED;
        end else begin
            state_q <= lfsr16_next(state_q);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/nexys_starship_monster_gen.sv
// -----------------------------------------------------------------------------
// nexys_starship_monster_gen
// Monster spawner for one ship side. After a guaranteed cooldown it spawns a
// monster pseudo-randomly (LFSR driven), runs the shoot-down countdown and
// flags the side as broken if the player does not shoot in time.
//
// Ports:
//   Clk               in   system clock
//   Reset             in   synchronous active-high reset
//   play_flag         in   game running (level); low forces IDLE
//   shoot             in   one-cycle debounced fire pulse for this side
//   top_monster_ctrl  out  monster present (level)
//   top_broken        out  side destroyed; sticky until IDLE
//   monster_timer     out  remaining monster life, 0 when none
//   q_MG_*            out  one-hot state (Idle/Cool/Armed/Active/Broken)
//   kill_count        out  [7:0] saturating shoot-down count
//                          (only with MONSTER_GEN_KILL_COUNT_EN defined)
//
// Optional feature macro: MONSTER_GEN_KILL_COUNT_EN
// -----------------------------------------------------------------------------
module nexys_starship_monster_gen
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED     = SEED_TOP,
    parameter logic [8:0]  SPAWN_THRESH  = 9'd8,
    parameter logic [31:0] MIN_GAP       = 32'd50_000_000,
    parameter logic [31:0] SHOOT_TIMEOUT = 32'd250_000_000,
    parameter int          TIMER_W       = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               play_flag,
    input  logic               shoot,
    output logic               top_monster_ctrl,
    output logic               top_broken,
    output logic [TIMER_W-1:0] monster_timer,
`ifdef MONSTER_GEN_KILL_COUNT_EN
    output logic [7:0]         kill_count,
`endif
    output logic               q_MG_Idle,
    output logic               q_MG_Cool,
    output logic               q_MG_Armed,
    output logic               q_MG_Active,
    output logic               q_MG_Broken
);

    // Loaded on cooldown entry; counting down to 0 gives exactly MIN_GAP cycles
    localparam logic [TIMER_W-1:0] GAP_RELOAD = TIMER_W'(MIN_GAP - 32'd1);
    localparam logic [TIMER_W-1:0] LIFE_LOAD  = TIMER_W'(SHOOT_TIMEOUT);
    localparam logic [TIMER_W-1:0] ONE        = TIMER_W'(1);

    // ---------------------------------------------------------------------
    // Pseudo-random source
    // ---------------------------------------------------------------------
    logic [15:0] lfsr_state;

    nexys_starship_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .state (lfsr_state)
    );

    // Only the low byte decides spawns; upper bits just extend the period
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_state[15:8];

    // 9-bit compare so a threshold of 256 hits on every value
    logic spawn_hit;
    assign spawn_hit = ({1'b0, lfsr_state[7:0]} < SPAWN_THRESH);

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    mg_state_t          state_q,  state_d;
    logic [TIMER_W-1:0] gap_q,    gap_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;
    logic               ctrl_q,   ctrl_d;
    logic               broken_q, broken_d;
`ifdef MONSTER_GEN_KILL_COUNT_EN
    logic [7:0]         kill_q,   kill_d;
`endif

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        timer_d  = timer_q;
        ctrl_d   = ctrl_q;
        broken_d = broken_q;
`ifdef MONSTER_GEN_KILL_COUNT_EN
        kill_d   = kill_q;
`endif

        if (!play_flag) begin
            // Game stopped: beats shoot and expiry, clears everything
            state_d  = MG_IDLE;
            gap_d    = '0;
            timer_d  = '0;
            ctrl_d   = 1'b0;
            broken_d = 1'b0;
`ifdef MONSTER_GEN_KILL_COUNT_EN
            kill_d   = 8'd0;
`endif
        end else begin
            case (state_q)
                MG_IDLE: begin
                    state_d  = MG_COOL;
                    gap_d    = GAP_RELOAD;
                    timer_d  = '0;
                    ctrl_d   = 1'b0;
                    broken_d = 1'b0;
                end

                MG_COOL: begin
                    if (gap_q == '0) begin
                        state_d = MG_ARMED;
                    end else begin
                        gap_d = gap_q - ONE;
                    end
                end

                MG_ARMED: begin
                    if (spawn_hit) begin
                        state_d = MG_ACTIVE;
                        ctrl_d  = 1'b1;
                        timer_d = LIFE_LOAD;
                    end
                end

                MG_ACTIVE: begin
                    // Shoot is checked first so a shot on the expiry cycle saves the ship
                    if (shoot) begin
                        state_d = MG_COOL;
                        ctrl_d  = 1'b0;
                        timer_d = '0;
                        gap_d   = GAP_RELOAD;
`ifdef MONSTER_GEN_KILL_COUNT_EN
                        if (kill_q != 8'hFF) begin
                            kill_d = kill_q + 8'd1;
                        end
`endif
                    end else if (timer_q == ONE) begin
                        state_d  = MG_BROKEN;
                        ctrl_d   = 1'b0;
                        timer_d  = '0;
                        broken_d = 1'b1;
                    end else begin
                        timer_d = timer_q - ONE;
                    end
                end

                MG_BROKEN: begin
                    // Terminal until play_flag drops
                    broken_d = 1'b1;
                    ctrl_d   = 1'b0;
                    timer_d  = '0;
                end

                default: begin
                    // Corrupted one-hot encoding: restart cleanly from IDLE
                    state_d  = MG_IDLE;
                    gap_d    = '0;
                    timer_d  = '0;
                    ctrl_d   = 1'b0;
                    broken_d = 1'b0;
`ifdef MONSTER_GEN_KILL_COUNT_EN
                    kill_d   = 8'd0;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= MG_IDLE;
            gap_q    <= '0;
            timer_q  <= '0;
            ctrl_q   <= 1'b0;
            broken_q <= 1'b0;
`ifdef MONSTER_GEN_KILL_COUNT_EN
            kill_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            timer_q  <= timer_d;
            ctrl_q   <= ctrl_d;
            broken_q <= broken_d;
`ifdef MONSTER_GEN_KILL_COUNT_EN
            kill_q   <= kill_d;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ---------------------------------------------------------------------
    assign top_monster_ctrl = ctrl_q;
    assign top_broken       = broken_q;
    assign monster_timer    = timer_q;
`ifdef MONSTER_GEN_KILL_COUNT_EN
    assign kill_count       = kill_q;
`endif

    assign q_MG_Idle   = state_q[0];
    assign q_MG_Cool   = state_q[1];
    assign q_MG_Armed  = state_q[2];
    assign q_MG_Active = state_q[3];
    assign q_MG_Broken = state_q[4];

endmodule

// File: tb/tb_nexys_starship_monster_gen.sv
// -----------------------------------------------------------------------------
// tb_nexys_starship_monster_gen
// Directed bench for nexys_starship_monster_gen. Three instances share the
// stimulus: spawn threshold 256 (main), 0 (never spawns) and 8 (LFSR driven).
// -----------------------------------------------------------------------------
module tb_nexys_starship_monster_gen;

    localparam logic [4:0] ST_IDLE   = 5'b00001;
    localparam logic [4:0] ST_COOL   = 5'b00010;
    localparam logic [4:0] ST_ARMED  = 5'b00100;
    localparam logic [4:0] ST_ACTIVE = 5'b01000;
    localparam logic [4:0] ST_BROKEN = 5'b10000;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic play_flag = 1'b0;
    logic shoot = 1'b0;

    always #5 Clk = ~Clk;

    wire        a_ctrl, n_ctrl, e_ctrl;
    wire        a_broken, n_broken, e_broken;
    wire [31:0] a_timer, n_timer, e_timer;
    wire [4:0]  a_st, n_st, e_st;
`ifdef MONSTER_GEN_KILL_COUNT_EN
    wire [7:0]  a_kill, n_kill, e_kill;
`endif

    nexys_starship_monster_gen #(
        .LFSR_SEED(SEED), .SPAWN_THRESH(9'd256), .MIN_GAP(32'd4),
        .SHOOT_TIMEOUT(32'd10), .TIMER_W(32)
    ) dut (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .shoot(shoot),
        .top_monster_ctrl(a_ctrl), .top_broken(a_broken), .monster_timer(a_timer),
`ifdef MONSTER_GEN_KILL_COUNT_EN
        .kill_count(a_kill),
`endif
        .q_MG_Idle(a_st[0]), .q_MG_Cool(a_st[1]), .q_MG_Armed(a_st[2]),
        .q_MG_Active(a_st[3]), .q_MG_Broken(a_st[4])
    );

    nexys_starship_monster_gen #(
        .LFSR_SEED(SEED), .SPAWN_THRESH(9'd0), .MIN_GAP(32'd4),
        .SHOOT_TIMEOUT(32'd10), .TIMER_W(32)
    ) dut_never (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .shoot(shoot),
        .top_monster_ctrl(n_ctrl), .top_broken(n_broken), .monster_timer(n_timer),
`ifdef MONSTER_GEN_KILL_COUNT_EN
        .kill_count(n_kill),
`endif
        .q_MG_Idle(n_st[0]), .q_MG_Cool(n_st[1]), .q_MG_Armed(n_st[2]),
        .q_MG_Active(n_st[3]), .q_MG_Broken(n_st[4])
    );

    nexys_starship_monster_gen #(
        .LFSR_SEED(SEED), .SPAWN_THRESH(9'd8), .MIN_GAP(32'd4),
        .SHOOT_TIMEOUT(32'd10), .TIMER_W(32)
    ) dut_t8 (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .shoot(shoot),
        .top_monster_ctrl(e_ctrl), .top_broken(e_broken), .monster_timer(e_timer),
`ifdef MONSTER_GEN_KILL_COUNT_EN
        .kill_count(e_kill),
`endif
        .q_MG_Idle(e_st[0]), .q_MG_Cool(e_st[1]), .q_MG_Armed(e_st[2]),
        .q_MG_Active(e_st[3]), .q_MG_Broken(e_st[4])
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // State, ctrl, broken and timer of the main instance in one go
    task automatic check_main(input string tag, input logic [4:0] st, input logic ctrl,
                              input logic brk, input logic [31:0] tmr);
        check({tag, ".state"}, 32'(a_st), 32'(st));
        check({tag, ".ctrl"}, 32'(a_ctrl), 32'(ctrl));
        check({tag, ".broken"}, 32'(a_broken), 32'(brk));
        check({tag, ".timer"}, a_timer, tmr);
    endtask

    task automatic check_kill(input string tag, input logic [7:0] exp);
`ifdef MONSTER_GEN_KILL_COUNT_EN
        check(tag, 32'(a_kill), 32'(exp));
`else
        if (exp == 8'hFF) $display("note: %s", tag);
`endif
    endtask

    function automatic logic [15:0] ref_next(input logic [15:0] cur);
        logic [15:0] sh;
        sh = cur >> 1;
        return cur[0] ? (sh ^ 16'hB400) : sh;
    endfunction

    initial begin
        int a_spawn;
        int e_spawn;
        int e_exp;
        int never_bad;
        logic [15:0] m;

        // --- 1: reset with play high, then the first spawn ---
        Reset = 1'b1;
        play_flag = 1'b1;
        repeat (3) step();
        check_main("reset", ST_IDLE, 1'b0, 1'b0, 32'd0);
        check("reset.lfsr", 32'(dut.lfsr_state), 32'(SEED));
        check_kill("reset.kill", 8'd0);
        Reset = 1'b0;
        step();
        check_main("s1.cool", ST_COOL, 1'b0, 1'b0, 32'd0);
        repeat (3) step();
        check("s1.cool4", 32'(a_st), 32'(ST_COOL));
        step();
        check("s1.armed", 32'(a_st), 32'(ST_ARMED));
        step();
        check_main("s1.active", ST_ACTIVE, 1'b1, 1'b0, 32'd10);

        // --- 2: no shot, monster expires ---
        for (int k = 1; k <= 9; k++) begin
            step();
            check("s2.count", a_timer, 32'(10 - k));
        end
        step();
        check_main("s2.broken", ST_BROKEN, 1'b0, 1'b1, 32'd0);
        for (int k = 0; k < 20; k++) begin
            step();
            check("s2.hold_brk", 32'(a_broken), 32'd1);
            check("s2.hold_st", 32'(a_st), 32'(ST_BROKEN));
        end
        play_flag = 1'b0;
        step();
        check_main("s2.idle", ST_IDLE, 1'b0, 1'b0, 32'd0);

        // --- 3: shoot at timer 6 ---
        play_flag = 1'b1;
        step();
        repeat (4) step();
        step();
        check_main("s3.active", ST_ACTIVE, 1'b1, 1'b0, 32'd10);
        repeat (4) step();
        check("s3.t6", a_timer, 32'd6);
        shoot = 1'b1;
        step();
        shoot = 1'b0;
        check_main("s3.shot", ST_COOL, 1'b0, 1'b0, 32'd0);
        check_kill("s3.kill", 8'd1);
        repeat (3) step();
        check("s3.cool", 32'(a_st), 32'(ST_COOL));
        step();
        check("s3.armed", 32'(a_st), 32'(ST_ARMED));
        step();
        check_main("s3.respawn", ST_ACTIVE, 1'b1, 1'b0, 32'd10);

        // --- 4: shoot on the expiry cycle, then stray shots ---
        repeat (9) step();
        check("s4.t1", a_timer, 32'd1);
        shoot = 1'b1;
        step();
        shoot = 1'b0;
        check_main("s4.saved", ST_COOL, 1'b0, 1'b0, 32'd0);
        check_kill("s4.kill", 8'd2);
        shoot = 1'b1;
        step();
        shoot = 1'b0;
        check("s4.cool_shot", 32'(a_st), 32'(ST_COOL));
        check_kill("s4.kill_cool", 8'd2);
        repeat (2) step();
        step();
        check("s4.armed", 32'(a_st), 32'(ST_ARMED));
        shoot = 1'b1;
        step();
        shoot = 1'b0;
        check_main("s4.armed_shot", ST_ACTIVE, 1'b1, 1'b0, 32'd10);
        check_kill("s4.kill_armed", 8'd2);

        // play_flag dropping together with a shot: IDLE wins
        play_flag = 1'b0;
        shoot = 1'b1;
        step();
        shoot = 1'b0;
        check_main("s4.stop_shot", ST_IDLE, 1'b0, 1'b0, 32'd0);
        check_kill("s4.kill_idle", 8'd0);

        // --- 6: reset mid-ACTIVE ---
        play_flag = 1'b1;
        repeat (6) step();
        check("s6.active", 32'(a_st), 32'(ST_ACTIVE));
        repeat (7) step();
        check("s6.t3", a_timer, 32'd3);
        Reset = 1'b1;
        step();
        check_main("s6.reset", ST_IDLE, 1'b0, 1'b0, 32'd0);
        check("s6.lfsr", 32'(dut.lfsr_state), 32'(SEED));

        // Reference spawn edge for threshold 8: ARMED from edge 6, edge k sees L(k-1)
        m = SEED;
        e_exp = -1;
        for (int k = 1; k <= 5000 && e_exp < 0; k++) begin
            if (k >= 6 && m[7:0] < 8'd8) e_exp = k;
            m = ref_next(m);
        end

        // --- 5/6: replay from reset on all three instances ---
        Reset = 1'b0;
        a_spawn = -1;
        e_spawn = -1;
        never_bad = 0;
        for (int i = 1; i <= 5000; i++) begin
            step();
            if (a_spawn < 0 && a_st == ST_ACTIVE) a_spawn = i;
            if (e_spawn < 0 && e_st == ST_ACTIVE) e_spawn = i;
            if (i <= 1000 && (n_ctrl !== 1'b0 || (n_st & 5'b11001) != 5'b0)) never_bad++;
            if (i >= 1000 && e_spawn >= 0) break;
        end
        check("s6.spawn_edge", 32'(a_spawn), 32'd6);
        check("s5.never", 32'(never_bad), 32'd0);
        check("s5.t8_spawn", 32'(e_spawn), 32'(e_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
